// File: rtl/ifetch_multi_pkg.sv
// Shared fetch-stage types: decode packet, NOP encoding and the fetch-queue FSM states.
package ifetch_multi_pkg;

  localparam int XLEN = 32;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic            valid;
    logic [31:0]     inst;
    logic [XLEN-1:0] npc;
    logic [XLEN-1:0] pc;
  } IF_ID_PACKET;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    MISS  = 2'd1,
    FULL  = 2'd2
  } IFQ_STATE;

  // An 8-byte block holds two instructions, except when fetch starts at its upper word.
  function automatic logic [1:0] block_count(input logic pc_bit2);
    return pc_bit2 ? 2'd1 : 2'd2;
  endfunction

endpackage

// File: rtl/ifq_prio_sel.sv
// Fixed-priority redirect arbiter: the lowest set request index wins and supplies the new PC.
module ifq_prio_sel
  import ifetch_multi_pkg::*;
#(
  parameter int NUM_REDIRECT = 3
) (
  input  logic [NUM_REDIRECT-1:0]           req,
  input  logic [NUM_REDIRECT-1:0][XLEN-1:0] target,
  output logic [NUM_REDIRECT-1:0]           gnt,
  output logic                              any_req,
  output logic [XLEN-1:0]                   sel_pc
);

  // Scan from the lowest priority upward so the highest-priority request overwrites last.
  always_comb begin
    gnt    = '0;
    sel_pc = '0;
    for (int i = NUM_REDIRECT - 1; i >= 0; i--) begin
      if (req[i]) begin
        gnt    = '0;
        gnt[i] = 1'b1;
        sel_pc = target[i];
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/ifetch_multi.sv
// Multi-instruction fetch stage: fetches 8-byte icache blocks into a circular fetch queue
// and presents the oldest FETCH_WIDTH entries to decode; redirects flush and retarget.
module ifetch_multi
  import ifetch_multi_pkg::*;
#(
  parameter int FETCH_WIDTH  = 2,
  parameter int QUEUE_DEPTH  = 8,
  parameter int NUM_REDIRECT = 3,
  localparam int DEQ_W = $clog2(FETCH_WIDTH + 1),
  localparam int CNT_W = $clog2(QUEUE_DEPTH + 1),
  localparam int PTR_W = $clog2(QUEUE_DEPTH)
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [NUM_REDIRECT-1:0]           redirect_req,
  input  logic [NUM_REDIRECT-1:0][XLEN-1:0] redirect_pc,
  input  logic                              stall,
  input  logic [63:0]                       Icache2proc_data,
  input  logic                              Icache2proc_data_valid,
  output logic [XLEN-1:0]                   proc2Icache_addr,
  output IF_ID_PACKET [FETCH_WIDTH-1:0]     if_packet,
  input  logic [DEQ_W-1:0]                  deq_count,
  output logic [CNT_W-1:0]                  queue_count,
  output logic [NUM_REDIRECT-1:0]           gnt_debug,
  output logic [XLEN-1:0]                   PC_reg_debug
);

  logic [XLEN-1:0]         pc_q, pc_d;
  IFQ_STATE                state_q, state_d;
  logic [PTR_W-1:0]        rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]        count_q;
  logic [NUM_REDIRECT-1:0] gnt, gnt_q;
  logic                    redirect;
  logic [XLEN-1:0]         redirect_target;

  logic [31:0]             inst_mem [QUEUE_DEPTH];
  logic [XLEN-1:0]         pc_mem   [QUEUE_DEPTH];

  logic [1:0]              blk_cnt;
  logic [CNT_W-1:0]        free_slots;
  logic                    has_room;
  logic                    enq;
  logic [CNT_W-1:0]        deq_req;
  logic [CNT_W-1:0]        deq_eff;
  logic [CNT_W-1:0]        enq_n;
  logic [XLEN-1:0]         next_block_pc;

  ifq_prio_sel #(
    .NUM_REDIRECT(NUM_REDIRECT)
  ) u_prio_sel (
    .req     (redirect_req),
    .target  (redirect_pc),
    .gnt     (gnt),
    .any_req (redirect),
    .sel_pc  (redirect_target)
  );

  // Room is judged on the occupancy before this cycle's dequeue, so freed slots are not reused until next cycle.
  assign blk_cnt       = block_count(pc_q[2]);
  assign free_slots    = CNT_W'(QUEUE_DEPTH) - count_q;
  assign has_room      = free_slots >= CNT_W'(blk_cnt);
  assign enq           = Icache2proc_data_valid && !stall && !redirect && has_room;
  assign deq_req       = CNT_W'(deq_count);
  assign deq_eff       = (deq_req < count_q) ? deq_req : count_q;
  assign enq_n         = enq ? CNT_W'(blk_cnt) : '0;
  assign next_block_pc = {pc_q[XLEN-1:3] + (XLEN-3)'(1), 3'b000};

  always_comb begin
    pc_d = pc_q;
    if (redirect) begin
      pc_d = redirect_target;
    end else if (enq) begin
      pc_d = next_block_pc;
    end
  end

  // The FSM only tracks why fetch is idle; enqueue decisions come straight from the room/valid checks.
  always_comb begin
    state_d = state_q;
    if (redirect) begin
      state_d = FETCH;
    end else begin
      case (state_q)
        FETCH: begin
          if (!Icache2proc_data_valid) begin
            state_d = MISS;
          end else if (!has_room) begin
            state_d = FULL;
          end
        end
        MISS: begin
          if (Icache2proc_data_valid) begin
            state_d = FETCH;
          end
        end
        FULL: begin
          if (has_room) begin
            state_d = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q     <= '0;
      state_q  <= FETCH;
      gnt_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
      gnt_q   <= gnt;
      if (redirect) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(deq_eff);
        wr_ptr_q <= wr_ptr_q + PTR_W'(enq_n);
        count_q  <= count_q - deq_eff + enq_n;
      end
    end
  end

  // Queue storage needs no reset: the occupancy count alone decides which entries are live.
  always_ff @(posedge clock) begin
    if (enq) begin
      inst_mem[wr_ptr_q] <= pc_q[2] ? Icache2proc_data[63:32] : Icache2proc_data[31:0];
      pc_mem[wr_ptr_q]   <= {pc_q[XLEN-1:2], 2'b00};
      if (!pc_q[2]) begin
        inst_mem[wr_ptr_q + PTR_W'(1)] <= Icache2proc_data[63:32];
        pc_mem[wr_ptr_q + PTR_W'(1)]   <= {pc_q[XLEN-1:3], 3'b100};
      end
    end
  end

  always_comb begin
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if_packet[i].valid = 1'b0;
      if_packet[i].inst  = NOP;
      if_packet[i].npc   = '0;
      if_packet[i].pc    = '0;
      if (CNT_W'(i) < count_q) begin
        if_packet[i].valid = 1'b1;
        if_packet[i].inst  = inst_mem[rd_ptr_q + PTR_W'(i)];
        if_packet[i].pc    = pc_mem[rd_ptr_q + PTR_W'(i)];
        if_packet[i].npc   = pc_mem[rd_ptr_q + PTR_W'(i)] + XLEN'(4);
      end
    end
  end

  // gnt_debug reports the redirect taken on the most recent clock edge, alongside the PC it loaded.
  assign proc2Icache_addr = {pc_q[XLEN-1:3], 3'b000};
  assign queue_count      = count_q;
  assign gnt_debug        = gnt_q;
  assign PC_reg_debug     = pc_q;

endmodule

// File: tb/tb_ifetch_multi.sv
// Randomized scoreboard bench for ifetch_multi: a queue-based reference model predicts every
// post-edge output; a negedge monitor pops predictions and compares them with the DUT.
module tb_ifetch_multi;
  import ifetch_multi_pkg::*;

  localparam int QD = 8;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } ent_t;

  typedef struct packed {
    logic [31:0]           addr;
    logic [3:0]            count;
    logic [2:0]            gnt;
    logic [31:0]           pcreg;
    IF_ID_PACKET [1:0]     pkt;
  } exp_t;

  logic                 clock;
  logic                 reset;
  logic [2:0]           redirect_req;
  logic [2:0][31:0]     redirect_pc;
  logic                 stall;
  logic [63:0]          Icache2proc_data;
  logic                 Icache2proc_data_valid;
  logic [31:0]          proc2Icache_addr;
  IF_ID_PACKET [1:0]    if_packet;
  logic [1:0]           deq_count;
  logic [3:0]           queue_count;
  logic [2:0]           gnt_debug;
  logic [31:0]          PC_reg_debug;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_pc;
  logic [2:0]  m_gnt;
  ent_t        m_q[$];
  exp_t        exp_q[$];
  exp_t        mon_exp;

  ifetch_multi dut (
    .clock                  (clock),
    .reset                  (reset),
    .redirect_req           (redirect_req),
    .redirect_pc            (redirect_pc),
    .stall                  (stall),
    .Icache2proc_data       (Icache2proc_data),
    .Icache2proc_data_valid (Icache2proc_data_valid),
    .proc2Icache_addr       (proc2Icache_addr),
    .if_packet              (if_packet),
    .deq_count              (deq_count),
    .queue_count            (queue_count),
    .gnt_debug              (gnt_debug),
    .PC_reg_debug           (PC_reg_debug)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    m_pc  = 32'h0;
    m_gnt = 3'b000;
    m_q.delete();
  endtask

  // Reference behaviour for one clock edge, expressed on a plain queue of fetched words.
  task automatic model_step(input logic [2:0] req, input logic [2:0][31:0] tgt, input logic st,
                            input logic v, input logic [63:0] data, input int dq);
    ent_t e;
    exp_t x;
    int   n;
    int   d;
    bit   room;
    if (req != 3'b000) begin
      for (int i = 0; i < 3; i++) begin
        if (req[i]) begin
          m_gnt = 3'b001 << i;
          m_pc  = tgt[i];
          break;
        end
      end
      m_q.delete();
    end else begin
      m_gnt = 3'b000;
      n     = m_pc[2] ? 1 : 2;
      room  = (QD - m_q.size()) >= n;
      d     = (dq < m_q.size()) ? dq : m_q.size();
      repeat (d) void'(m_q.pop_front());
      if (v && !st && room) begin
        if (!m_pc[2]) begin
          e.inst = data[31:0];  e.pc = m_pc & ~32'h7;          m_q.push_back(e);
          e.inst = data[63:32]; e.pc = (m_pc & ~32'h7) + 32'd4; m_q.push_back(e);
        end else begin
          e.inst = data[63:32]; e.pc = m_pc & ~32'h3;          m_q.push_back(e);
        end
        m_pc = (m_pc & ~32'h7) + 32'd8;
      end
    end
    x.addr  = m_pc & ~32'h7;
    x.count = 4'(m_q.size());
    x.gnt   = m_gnt;
    x.pcreg = m_pc;
    for (int i = 0; i < 2; i++) begin
      if (i < m_q.size()) begin
        x.pkt[i].valid = 1'b1;
        x.pkt[i].inst  = m_q[i].inst;
        x.pkt[i].pc    = m_q[i].pc;
        x.pkt[i].npc   = m_q[i].pc + 32'd4;
      end else begin
        x.pkt[i].valid = 1'b0;
        x.pkt[i].inst  = NOP;
        x.pkt[i].pc    = 32'h0;
        x.pkt[i].npc   = 32'h0;
      end
    end
    exp_q.push_back(x);
  endtask

  task automatic apply_stimulus(input logic [2:0] req, input logic [31:0] p0, input logic [31:0] p1,
                                input logic [31:0] p2, input logic st, input logic v, input int dq);
    logic [2:0][31:0] tgt;
    logic [63:0]      data;
    @(negedge clock);
    #1;
    tgt[0] = p0; tgt[1] = p1; tgt[2] = p2;
    data   = {$urandom, $urandom};
    redirect_req           = req;
    redirect_pc            = tgt;
    stall                  = st;
    Icache2proc_data       = data;
    Icache2proc_data_valid = v;
    deq_count              = 2'(dq);
    model_step(req, tgt, st, v, data, dq);
  endtask

  task automatic idle_inputs();
    redirect_req           = 3'b000;
    redirect_pc            = '0;
    stall                  = 1'b0;
    Icache2proc_data       = 64'h0;
    Icache2proc_data_valid = 1'b0;
    deq_count              = 2'd0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, " proc2Icache_addr"}, 128'(proc2Icache_addr), 128'(32'h0));
    check_output({tag, " queue_count"},      128'(queue_count),      128'(4'd0));
    check_output({tag, " gnt_debug"},        128'(gnt_debug),        128'(3'b000));
    check_output({tag, " PC_reg_debug"},     128'(PC_reg_debug),     128'(32'h0));
    check_output({tag, " pkt0.valid"},       128'(if_packet[0].valid), 128'(1'b0));
    check_output({tag, " pkt1.valid"},       128'(if_packet[1].valid), 128'(1'b0));
  endtask

  // Scoreboard monitor: each negedge consumes one prediction made for the preceding clock edge.
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      check_output("proc2Icache_addr", 128'(proc2Icache_addr), 128'(mon_exp.addr));
      check_output("queue_count",      128'(queue_count),      128'(mon_exp.count));
      check_output("gnt_debug",        128'(gnt_debug),        128'(mon_exp.gnt));
      check_output("PC_reg_debug",     128'(PC_reg_debug),     128'(mon_exp.pcreg));
      check_output("if_packet[0]",     128'(if_packet[0]),     128'(mon_exp.pkt[0]));
      check_output("if_packet[1]",     128'(if_packet[1]),     128'(mon_exp.pkt[1]));
    end
  end

  initial begin
    logic [2:0] rq;
    reset = 1'b0;
    idle_inputs();
    model_reset();
    repeat (2) @(negedge clock);
    #1;
    check_reset_outputs("reset");
    reset = 1'b1;

    // Streaming hits from reset until the queue fills, then holds while full.
    for (int k = 0; k < 6; k++) apply_stimulus(3'b000, 0, 0, 0, 1'b0, 1'b1, 0);
    // Full queue with dequeue: first cycle only drains, second refills.
    apply_stimulus(3'b000, 0, 0, 0, 1'b0, 1'b1, 2);
    apply_stimulus(3'b000, 0, 0, 0, 1'b0, 1'b1, 2);
    // All three redirect sources at once.
    apply_stimulus(3'b111, 32'h1111_1110, 32'h2222_2220, 32'h3333_3330, 1'b0, 1'b1, 0);
    // Redirect into the upper word of a block.
    apply_stimulus(3'b010, 0, 32'h0000_0104, 0, 1'b1, 1'b1, 1);
    apply_stimulus(3'b000, 0, 0, 0, 1'b0, 1'b1, 0);
    // Extended miss at 0x40, then the block arrives.
    apply_stimulus(3'b100, 0, 0, 32'h0000_0040, 1'b0, 1'b0, 0);
    for (int k = 0; k < 10; k++) apply_stimulus(3'b000, 0, 0, 0, 1'b0, 1'b0, 0);
    apply_stimulus(3'b000, 0, 0, 0, 1'b0, 1'b1, 0);
    // Stall blocks enqueue but still lets decode drain.
    apply_stimulus(3'b000, 0, 0, 0, 1'b1, 1'b1, 1);

    // Asynchronous reset in the middle of a miss.
    apply_stimulus(3'b001, 32'h0000_0200, 0, 0, 1'b0, 1'b1, 0);
    apply_stimulus(3'b000, 0, 0, 0, 1'b0, 1'b1, 0);
    apply_stimulus(3'b000, 0, 0, 0, 1'b0, 1'b0, 0);
    @(negedge clock);
    #1;
    idle_inputs();
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    @(negedge clock);
    #1;
    reset = 1'b1;
    model_reset();
    check_output("post_reset addr", 128'(proc2Icache_addr), 128'(32'h0));
    apply_stimulus(3'b000, 0, 0, 0, 1'b0, 1'b1, 0);

    // Randomized traffic.
    for (int k = 0; k < 600; k++) begin
      rq[0] = ($urandom_range(0, 19) == 0);
      rq[1] = ($urandom_range(0, 19) == 0);
      rq[2] = ($urandom_range(0, 11) == 0);
      apply_stimulus(rq, $urandom & ~32'h3, $urandom & ~32'h3, $urandom & ~32'h3,
                     ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0),
                     int'($urandom_range(0, 2)));
    end

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clock);
    #2;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_drain: %0d predictions left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifetch_multi.md
IFETCH_MULTI -- requirements
Module: ifetch_multi

Interface
REQ-001 Parameter FETCH_WIDTH, default 2, max instructions presented to decode per cycle (1 or 2).
REQ-002 Parameter QUEUE_DEPTH, default 8, fetch-queue entries, power of two, at least 2.
REQ-003 Parameter NUM_REDIRECT, default 3, redirect sources; index 0 highest priority (0 = EX certain branch, 1 = ROB target, 2 = branch predictor).
REQ-004 clock  in  1  sole clock; all state updates on the rising edge.
REQ-005 reset  in  1  asynchronous, active-low; 0 forces reset state immediately.
REQ-006 redirect_req  in  NUM_REDIRECT  per-source redirect request.
REQ-007 redirect_pc  in  NUM_REDIRECT x XLEN  per-source target PC.
REQ-008 stall  in  1  holds the PC and blocks enqueue; dequeue is unaffected.
REQ-009 Icache2proc_data  in  64  8-byte block for proc2Icache_addr.
REQ-010 Icache2proc_data_valid  in  1  Icache2proc_data is valid this cycle.
REQ-011 proc2Icache_addr  out  XLEN  {PC[XLEN-1:3], 3'b000}.
REQ-012 if_packet  out  FETCH_WIDTH x IF_ID_PACKET  oldest queue entries, in order.
REQ-013 deq_count  in  clog2(FETCH_WIDTH+1)  entries decode consumes this cycle.
REQ-014 queue_count  out  clog2(QUEUE_DEPTH+1)  occupied entries.
REQ-015 gnt_debug  out  NUM_REDIRECT  one-hot winning redirect, or zero; PC_reg_debug  out  XLEN  PC register.

Function
REQ-016 Block instruction count is 2 when PC[2]=0 and 1 when PC[2]=1 (upper word only).
REQ-017 Enqueue fires when valid=1, stall=0, no redirect, and QUEUE_DEPTH-queue_count >= block count; room uses the pre-dequeue count with no same-cycle bypass.
REQ-018 On enqueue, write entries in address order with inst = word at PC, PC = word address, NPC = PC+4, valid=1, and set PC to {PC[XLEN-1:3]+1, 3'b000}.
REQ-019 Dequeue removes min(deq_count, queue_count) oldest entries; enqueue and dequeue may both occur in one cycle.
REQ-020 if_packet[i].valid=1 iff i < queue_count; invalid slots output inst = NOP and PC = 0.
REQ-021 Redirect: lowest set index wins; next PC = its redirect_pc; queue flushed (count 0); this cycle's icache data and dequeue discarded; gnt_debug one-hot.
REQ-022 Redirect overrides stall, full queue and miss.
REQ-023 FSM states FETCH, MISS, FULL; all states go to FETCH on redirect.
REQ-024 FETCH goes to MISS on valid=0, to FULL on insufficient room, and otherwise stays.
REQ-025 MISS goes to FETCH on the cycle after valid=1 is seen.
REQ-026 FULL goes to FETCH once the room check passes.
REQ-027 The state is observable only through behaviour; proc2Icache_addr is held in every state.
REQ-028 Read/write pointers wrap modulo QUEUE_DEPTH; the count is a separate register, so full and empty are unambiguous.

Reset
REQ-029 While reset=0: PC = 0, queue_count = 0, pointers = 0, state = FETCH, gnt_debug = 0, all if_packet valid = 0.
REQ-030 Reset asserted mid-miss or mid-enqueue discards all in-flight state; the first request after release is address 0.

Structure
REQ-031 IF_ID_PACKET, XLEN and NOP come from sys_defs; add an IFQ_STATE enum (FETCH, MISS, FULL) to the shared package.
REQ-032 One sub-module, ifq_prio_sel, performs the NUM_REDIRECT fixed-priority one-hot select and PC mux.

Verification
REQ-033 Scenario 1: all three requests with PCs 1111_1110, 2222_2220, 3333_3330 -> gnt_debug=001, PC_reg_debug=1111_1110, queue_count=0.
REQ-034 Scenario 2: from reset, icache always hit, deq_count=0, QUEUE_DEPTH=8 -> requests 0x0, 0x8, 0x10, 0x18; queue_count steps 2, 4, 6, 8 and then holds (FULL).
REQ-035 Scenario 3: redirect to 0x104 -> one entry enqueued (PC 0x104), next request 0x108.
REQ-036 Scenario 4: queue full with deq_count=2 and a hit -> cycle 1 count 6 (no bypass), cycle 2 enqueue, count 6.
REQ-037 Scenario 5: valid=0 for 10 cycles at 0x40 -> address held at 0x40, count unchanged; on valid=1 entries 0x40 and 0x44 are written.
REQ-038 Scenario 6: reset=0 asynchronously mid-miss -> outputs reset without a clock edge; after release the request is 0x0.
